mmio_ctrl: RTL and testbench

//  Parametrised memory-mapped I/O controller for the single-cycle core.
//  - Replaces fixed KEY/SW/HEX/LEDR/LEDG decode in data memory.
//  - Adds input synchronisation and debounce, per-key sticky press flags and a programmable timer.
//  - Provides one level interrupt line.
//  - Sits beside data memory; the core routes any address in the I/O window here.

---
 rtl/mmio_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mmio_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: LED/HEX outputs, debounced keys and switches,
// sticky key-press flags, a programmable wrap timer and one level interrupt.
module mmio_ctrl #(
    parameter int                 DBITS      = 32,
    parameter logic [DBITS-1:0]   ADDR_BASE  = DBITS'(32'hF000_0000),
    parameter int                 NUM_KEYS   = 4,
    parameter int                 NUM_SW     = 10,
    parameter int                 NUM_LEDR   = 10,
    parameter int                 NUM_LEDG   = 8,
    parameter int                 HEX_DIGITS = 4,
    parameter int                 DEBOUNCE   = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DBITS-1:0]        addr,
    input  logic                    wr_en,
    input  logic [DBITS-1:0]        wr_data,
    output logic                    hit,
    output logic [DBITS-1:0]        rd_data,
    input  logic [NUM_KEYS-1:0]     KEY,
    input  logic [NUM_SW-1:0]       SW,
    output logic [4*HEX_DIGITS-1:0] HEX,
    output logic [NUM_LEDR-1:0]     LEDR,
    output logic [NUM_LEDG-1:0]     LEDG,
    output logic                    irq
);

    localparam int HEXW = 4 * HEX_DIGITS;
    localparam int NIN  = NUM_KEYS + NUM_SW;
    localparam int CW   = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  DB_TOP = CW'(DEBOUNCE - 1);
    // Raw-pin idle levels: keys released (1), switches low.
    localparam logic [NIN-1:0] IN_RST = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};

    localparam logic [DBITS-1:0] OFF_HEX   = DBITS'(32'h00);
    localparam logic [DBITS-1:0] OFF_LEDR  = DBITS'(32'h04);
    localparam logic [DBITS-1:0] OFF_LEDG  = DBITS'(32'h08);
    localparam logic [DBITS-1:0] OFF_KDATA = DBITS'(32'h10);
    localparam logic [DBITS-1:0] OFF_SDATA = DBITS'(32'h14);
    localparam logic [DBITS-1:0] OFF_KPEND = DBITS'(32'h18);
    localparam logic [DBITS-1:0] OFF_KIE   = DBITS'(32'h1C);
    localparam logic [DBITS-1:0] OFF_TCNT  = DBITS'(32'h20);
    localparam logic [DBITS-1:0] OFF_TLIM  = DBITS'(32'h24);
    localparam logic [DBITS-1:0] OFF_TCTRL = DBITS'(32'h28);

    logic [HEXW-1:0]     hex_q, hex_d;
    logic [NUM_LEDR-1:0] ledr_q, ledr_d;
    logic [NUM_LEDG-1:0] ledg_q, ledg_d;
    logic [NIN-1:0]      sync1_q, sync1_d;
    logic [NIN-1:0]      sync2_q, sync2_d;
    logic [NIN-1:0]      deb_q, deb_d;
    logic [CW-1:0]       cnt_q [NIN];
    logic [CW-1:0]       cnt_d [NIN];
    logic [NUM_KEYS-1:0] kpend_q, kpend_d;
    logic [NUM_KEYS-1:0] kie_q, kie_d;
    logic [DBITS-1:0]    tcnt_q, tcnt_d;
    logic [DBITS-1:0]    tlim_q, tlim_d;
    logic                en_q, en_d;
    logic                ie_q, ie_d;
    logic                wrap_q, wrap_d;
    logic                irq_q, irq_d;

    logic [DBITS-1:0]    off;
    logic                sel_hex, sel_ledr, sel_ledg, sel_kpend, sel_kie;
    logic                sel_tcnt, sel_tlim, sel_tctrl;
    logic [NUM_KEYS-1:0] kdata_cur, kdata_nxt, kpend_clr;
    logic                wr, wrap_set, tc_hit;

    // Debounced key level is stored as the raw pin value; KDATA reports it inverted.
    assign kdata_cur = ~deb_q[NUM_KEYS-1:0];
    assign kdata_nxt = ~deb_d[NUM_KEYS-1:0];

    always_comb begin
        off       = addr - ADDR_BASE;
        hit       = 1'b1;
        rd_data   = '0;
        sel_hex   = 1'b0;
        sel_ledr  = 1'b0;
        sel_ledg  = 1'b0;
        sel_kpend = 1'b0;
        sel_kie   = 1'b0;
        sel_tcnt  = 1'b0;
        sel_tlim  = 1'b0;
        sel_tctrl = 1'b0;
        case (off)
            OFF_HEX:   begin sel_hex   = 1'b1; rd_data = DBITS'(hex_q);  end
            OFF_LEDR:  begin sel_ledr  = 1'b1; rd_data = DBITS'(ledr_q); end
            OFF_LEDG:  begin sel_ledg  = 1'b1; rd_data = DBITS'(ledg_q); end
            OFF_KDATA: rd_data = DBITS'(kdata_cur);
            OFF_SDATA: rd_data = DBITS'(deb_q[NIN-1:NUM_KEYS]);
            OFF_KPEND: begin sel_kpend = 1'b1; rd_data = DBITS'(kpend_q); end
            OFF_KIE:   begin sel_kie   = 1'b1; rd_data = DBITS'(kie_q);   end
            OFF_TCNT:  begin sel_tcnt  = 1'b1; rd_data = tcnt_q;          end
            OFF_TLIM:  begin sel_tlim  = 1'b1; rd_data = tlim_q;          end
            OFF_TCTRL: begin sel_tctrl = 1'b1; rd_data = DBITS'({wrap_q, ie_q, en_q}); end
            default:   hit = 1'b0;
        endcase
    end

    always_comb begin
        wr      = wr_en & hit;
        hex_d   = (wr && sel_hex)  ? wr_data[HEXW-1:0]     : hex_q;
        ledr_d  = (wr && sel_ledr) ? wr_data[NUM_LEDR-1:0] : ledr_q;
        ledg_d  = (wr && sel_ledg) ? wr_data[NUM_LEDG-1:0] : ledg_q;
        kie_d   = (wr && sel_kie)  ? wr_data[NUM_KEYS-1:0] : kie_q;
        tlim_d  = (wr && sel_tlim) ? wr_data               : tlim_q;

        sync1_d = {SW, KEY};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_TOP) deb_d[i] = sync2_q[i];
                else                    cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end

        // A press detected on the same edge as a W1C clear keeps the flag set.
        kpend_clr = (wr && sel_kpend) ? wr_data[NUM_KEYS-1:0] : '0;
        kpend_d   = (kpend_q & ~kpend_clr) | (kdata_nxt & ~kdata_cur);

        tc_hit   = (tlim_q != '0) ? (tcnt_q == tlim_q - DBITS'(1)) : (&tcnt_q);
        tcnt_d   = tcnt_q;
        wrap_set = 1'b0;
        if (wr && sel_tcnt) begin
            tcnt_d = wr_data;
        end else if (en_q) begin
            if (tc_hit) begin
                tcnt_d   = '0;
                wrap_set = 1'b1;
            end else begin
                tcnt_d = tcnt_q + DBITS'(1);
            end
        end

        en_d   = (wr && sel_tctrl) ? wr_data[0] : en_q;
        ie_d   = (wr && sel_tctrl) ? wr_data[1] : ie_q;
        wrap_d = (wrap_q & ~(wr && sel_tctrl && wr_data[2])) | wrap_set;

        irq_d  = (|(kpend_q & kie_q)) | (wrap_q & ie_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q   <= '0;
            ledr_q  <= '0;
            ledg_q  <= '0;
            sync1_q <= IN_RST;
            sync2_q <= IN_RST;
            deb_q   <= IN_RST;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
            kpend_q <= '0;
            kie_q   <= '0;
            tcnt_q  <= '0;
            tlim_q  <= '0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            wrap_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            hex_q   <= hex_d;
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
            kpend_q <= kpend_d;
            kie_q   <= kie_d;
            tcnt_q  <= tcnt_d;
            tlim_q  <= tlim_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            wrap_q  <= wrap_d;
            irq_q   <= irq_d;
        end
    end

    assign HEX  = hex_q;
    assign LEDR = ledr_q;
    assign LEDG = ledg_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with DEBOUNCE=4: register access, debounce timing,
// sticky flags, timer wrap, interrupt timing and asynchronous reset.
module tb_mmio_ctrl;

    localparam logic [31:0] B      = 32'hF000_0000;
    localparam logic [31:0] A_HEX  = B + 32'h00;
    localparam logic [31:0] A_LEDR = B + 32'h04;
    localparam logic [31:0] A_LEDG = B + 32'h08;
    localparam logic [31:0] A_KDAT = B + 32'h10;
    localparam logic [31:0] A_SDAT = B + 32'h14;
    localparam logic [31:0] A_KPND = B + 32'h18;
    localparam logic [31:0] A_KIE  = B + 32'h1C;
    localparam logic [31:0] A_TCNT = B + 32'h20;
    localparam logic [31:0] A_TLIM = B + 32'h24;
    localparam logic [31:0] A_TCTL = B + 32'h28;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        hit;
    logic [31:0] rd_data;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic [15:0] HEX;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;
    logic        irq;

    int tests = 0;
    int fails = 0;

    mmio_ctrl #(.DEBOUNCE(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .hit(hit), .rd_data(rd_data), .KEY(KEY), .SW(SW), .HEX(HEX),
        .LEDR(LEDR), .LEDG(LEDG), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check({tag, ".hit"}, {31'd0, hit}, 32'd1);
        check(tag, rd_data, exp);
    endtask

    initial begin
        tick(3);
        check("rst_hex", {16'd0, HEX}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        tick(1);
        rd("rst_kdata", A_KDAT, 32'd0);
        rd("rst_sdata", A_SDAT, 32'd0);
        rd("rst_tctrl", A_TCTL, 32'd0);

        wr(A_HEX, 32'h0000_BEEF);
        check("hex_out", {16'd0, HEX}, 32'h0000_BEEF);
        wr(A_LEDR, 32'hFFFF_FFFF);
        check("ledr_out", {22'd0, LEDR}, 32'h3FF);
        wr(A_LEDG, 32'h0000_00A5);
        check("ledg_out", {24'd0, LEDG}, 32'hA5);
        rd("hex_rd", A_HEX, 32'h0000_BEEF);
        rd("ledr_rd", A_LEDR, 32'h3FF);

        addr = B + 32'h2C; #1;
        check("unmap2c_hit", {31'd0, hit}, 32'd0);
        check("unmap2c_rd", rd_data, 32'd0);
        addr = 32'hE000_0000; #1;
        check("unmapE_hit", {31'd0, hit}, 32'd0);
        check("unmapE_rd", rd_data, 32'd0);
        wr(B + 32'h2C, 32'h1234_5678);
        wr(32'hE000_0000, 32'h1234_5678);
        check("unmap_nochg_hex", {16'd0, HEX}, 32'h0000_BEEF);
        check("unmap_nochg_ledr", {22'd0, LEDR}, 32'h3FF);

        // Clean press of KEY[0]: KDATA rises 6 edges after the pin.
        KEY = 4'b1110;
        tick(5);
        rd("press_kdata_early", A_KDAT, 32'd0);
        rd("press_kpend_early", A_KPND, 32'd0);
        tick(1);
        rd("press_kdata", A_KDAT, 32'h1);
        rd("press_kpend", A_KPND, 32'h1);
        check("press_irq_masked", {31'd0, irq}, 32'd0);
        wr(A_KPND, 32'h0);
        rd("kpend_w0", A_KPND, 32'h1);
        wr(A_KPND, 32'h1);
        rd("kpend_w1c", A_KPND, 32'h0);
        KEY = 4'hF;
        tick(6);
        rd("release_kdata", A_KDAT, 32'd0);
        rd("release_kpend", A_KPND, 32'd0);

        SW = 10'h2A5;
        tick(6);
        rd("sdata", A_SDAT, 32'h2A5);

        // Three-cycle glitch on KEY[1] is filtered.
        KEY = 4'b1101;
        tick(3);
        KEY = 4'hF;
        tick(8);
        rd("glitch_kdata", A_KDAT, 32'd0);
        rd("glitch_kpend", A_KPND, 32'd0);

        wr(A_KIE, 32'h1);
        KEY = 4'b1110;
        tick(6);
        rd("irq_kpend", A_KPND, 32'h1);
        check("irq_same_cycle", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq_asserted", {31'd0, irq}, 32'd1);
        wr(A_KPND, 32'h1);
        rd("irq_kpend_clr", A_KPND, 32'h0);
        check("irq_lag", {31'd0, irq}, 32'd1);
        tick(1);
        check("irq_deassert", {31'd0, irq}, 32'd0);

        // Press detected on the same edge as a W1C: set wins.
        KEY = 4'hF;
        tick(6);
        KEY = 4'b1110;
        tick(5);
        wr(A_KPND, 32'h1);
        rd("set_beats_clr", A_KPND, 32'h1);
        wr(A_KPND, 32'h1);
        wr(A_KIE, 32'h0);
        tick(1);
        check("irq_after_kie0", {31'd0, irq}, 32'd0);

        // Timer: TLIM=5 counts 0..4 then wraps.
        wr(A_TLIM, 32'd5);
        wr(A_TCTL, 32'h3);
        rd("tcnt_0", A_TCNT, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            rd("tcnt_run", A_TCNT, k);
            rd("tctrl_run", A_TCTL, 32'h3);
            check("irq_run", {31'd0, irq}, 32'd0);
        end
        tick(1);
        rd("tcnt_wrap", A_TCNT, 32'd0);
        rd("tctrl_wrap", A_TCTL, 32'h7);
        check("irq_wrap_lag", {31'd0, irq}, 32'd0);
        tick(1);
        rd("tcnt_after_wrap", A_TCNT, 32'd1);
        check("irq_wrap", {31'd0, irq}, 32'd1);
        wr(A_TCTL, 32'h7);
        rd("tctrl_w1c", A_TCTL, 32'h3);
        tick(1);
        check("irq_wrap_clr", {31'd0, irq}, 32'd0);

        wr(A_TCNT, 32'd100);
        rd("tcnt_wr", A_TCNT, 32'd100);
        tick(1);
        rd("tcnt_above_lim", A_TCNT, 32'd101);
        rd("tctrl_above_lim", A_TCTL, 32'h3);

        wr(A_TCNT, 32'hFFFF_FFFE);
        wr(A_TLIM, 32'd0);
        rd("tcnt_max", A_TCNT, 32'hFFFF_FFFF);
        tick(1);
        rd("tcnt_full_wrap", A_TCNT, 32'd0);
        rd("tctrl_full_wrap", A_TCTL, 32'h7);

        // Hardware wrap on the same edge as a W1C clear keeps wrap set.
        wr(A_TCNT, 32'hFFFF_FFFE);
        wr(A_TCTL, 32'h3);
        rd("tctrl_wrap_kept_prior", A_TCTL, 32'h7);
        wr(A_TCTL, 32'h7);
        rd("tcnt_hw_wrap", A_TCNT, 32'd0);
        rd("wrap_beats_w1c", A_TCTL, 32'h7);
        wr(A_TCTL, 32'h7);
        rd("tctrl_clr2", A_TCTL, 32'h3);

        // Asynchronous reset mid-count.
        wr(A_TCNT, 32'd3);
        check("pre_rst_ledr", {22'd0, LEDR}, 32'h3FF);
        #2;
        reset = 1'b1;
        #1;
        check("arst_hex", {16'd0, HEX}, 32'd0);
        check("arst_ledr", {22'd0, LEDR}, 32'd0);
        check("arst_ledg", {24'd0, LEDG}, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        rd("arst_tcnt", A_TCNT, 32'd0);
        tick(1);
        reset = 1'b0;
        KEY = 4'hF;
        tick(1);
        rd("arst_tctrl", A_TCTL, 32'd0);
        rd("arst_kpend", A_KPND, 32'd0);
        rd("arst_kie", A_KIE, 32'd0);
        rd("arst_tlim", A_TLIM, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
